// File: rtl/commit_trace_pkg.sv
// Shared types and helpers for the commit trace aligner.
package commit_trace_pkg;

    localparam int TRACE_XLEN = 64;

    // One buffered retire record; wdata is final only once pending is clear.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           inst;
        logic [TRACE_XLEN-1:0] wdata;
        logic [4:0]            rd;
        logic                  pending;
    } trace_entry_t;

    // Index width for a DEPTH-entry ring (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trace_pending_match.sv
// Picks the oldest pending entry whose rd matches, counting age from the head.
module trace_pending_match
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW = ptr_width(DEPTH)
) (
    input  logic [DEPTH-1:0] pending,
    input  logic [DEPTH-1:0] rd_eq,
    input  logic [IW-1:0]    head,
    output logic [DEPTH-1:0] match,
    output logic             hit
);

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] rot;
    logic [DEPTH-1:0] pri;
    logic             found;

    // Rotate so the head sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        cand  = pending & rd_eq;
        rot   = '0;
        pri   = '0;
        match = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) rot[i] = cand[IW'(i) + head];
        for (int i = 0; i < DEPTH; i++) begin
            if (rot[i] && !found) begin
                pri[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) match[IW'(i) + head] = pri[i];
        hit = |cand;
    end

endmodule

// File: rtl/commit_trace_aligner.sv
// In-order retire buffer that holds records until long-latency data arrives.
module commit_trace_aligner
    import commit_trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int XLEN    = TRACE_XLEN,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_wdata,
    input  logic [4:0]                 in_rd,
    input  logic                       in_pending,
    input  logic                       ll_wen,
    input  logic [4:0]                 ll_waddr,
    input  logic [XLEN-1:0]            ll_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_wdata,
    output logic [4:0]                 out_rd,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_overflow,
    output logic                       err_orphan,
    output logic                       err_timeout
);

    localparam int IW = ptr_width(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    trace_entry_t     mem [DEPTH];
    trace_entry_t     head_e;
    trace_entry_t     new_e;
    logic [PW-1:0]    head, tail, used;
    logic             empty, full, deq, enq, drop;
    logic [DEPTH-1:0] pend_vec, eq_vec, match;
    logic             hit;
    logic [TW-1:0]    tmo_cnt;

    assign used   = tail - head;
    assign empty  = (head == tail);
    assign full   = (head[IW] != tail[IW]) && (head[IW-1:0] == tail[IW-1:0]);
    assign head_e = mem[head[IW-1:0]];
    assign deq    = out_valid && out_ready;
    assign enq    = in_valid && (!full || deq);
    assign drop   = in_valid && full && !deq;
    assign count  = CW'(used);

    // Head record presented combinationally; all zero when empty.
    always_comb begin
        out_valid = !empty && !head_e.pending;
        out_pc    = empty ? '0 : head_e.pc;
        out_inst  = empty ? '0 : head_e.inst;
        out_wdata = empty ? '0 : head_e.wdata;
        out_rd    = empty ? '0 : head_e.rd;
    end

    // Match candidates: resident entries still waiting on data for ll_waddr.
    always_comb begin
        pend_vec = '0;
        eq_vec   = '0;
        for (int i = 0; i < DEPTH; i++) begin : g_cand
            logic [IW-1:0] off;
            off         = IW'(i) - head[IW-1:0];
            pend_vec[i] = mem[i].pending && ({1'b0, off} < used);
            eq_vec[i]   = (mem[i].rd == ll_waddr);
        end
    end

    // Incoming record; data is zeroed while it waits for its writeback.
    always_comb begin
        new_e.pc      = in_pc;
        new_e.inst    = in_inst;
        new_e.wdata   = in_pending ? '0 : in_wdata;
        new_e.rd      = in_rd;
        new_e.pending = in_pending;
    end

    trace_pending_match #(.DEPTH(DEPTH)) u_match (
        .pending (pend_vec),
        .rd_eq   (eq_vec),
        .head    (head[IW-1:0]),
        .match   (match),
        .hit     (hit)
    );

    // Storage: enqueue at tail, complete the matched pending entry in place.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (enq) mem[tail[IW-1:0]] <= new_e;
            if (ll_wen && hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (match[i]) begin
                        mem[i].wdata   <= ll_wdata;
                        mem[i].pending <= 1'b0;
                    end
                end
            end
        end
    end

    // Ring pointers and sticky overflow/orphan flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            if (drop) err_overflow <= 1'b1;
            if (ll_wen && !hit) err_orphan <= 1'b1;
        end
    end

    // Head-stall watchdog; saturates at the limit and flags once reached.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else if (deq || empty || !head_e.pending) begin
            tmo_cnt <= '0;
        end else if (TIMEOUT != 0 && tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt + 1'b1 == TMO_MAX) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_trace_aligner.sv
// Directed bench for commit_trace_aligner (DEPTH=8, TIMEOUT=16).
module tb_commit_trace_aligner;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_pending, ll_wen, out_ready;
    logic [63:0] in_pc, in_wdata, ll_wdata;
    logic [31:0] in_inst;
    logic [4:0]  in_rd, ll_waddr;
    logic        out_valid;
    logic [63:0] out_pc, out_wdata;
    logic [31:0] out_inst;
    logic [4:0]  out_rd;
    logic [3:0]  count;
    logic        err_overflow, err_orphan, err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    commit_trace_aligner #(.DEPTH(8), .XLEN(64), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata),
        .in_rd(in_rd), .in_pending(in_pending),
        .ll_wen(ll_wen), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_wdata(out_wdata), .out_rd(out_rd), .count(count),
        .err_overflow(err_overflow), .err_orphan(err_orphan), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic retire(input logic [63:0] pc, input logic [63:0] wd, input logic [4:0] rd,
                          input logic pend);
        in_valid = 1'b1; in_pc = pc; in_inst = 32'h0010_0093; in_wdata = wd;
        in_rd = rd; in_pending = pend;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_wdata = '0; in_rd = '0;
        in_pending = 1'b0; ll_wen = 1'b0; ll_waddr = '0; ll_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (out_pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", out_pc); end
        n_cmp++; if ({err_overflow, err_orphan, err_timeout} !== 3'b000) begin
            n_fail++; $display("FAIL reset_errs got %b want 000", {err_overflow, err_orphan, err_timeout}); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 64'h8000_0000; in_inst = 32'h0010_0093; in_wdata = 64'd1;
        in_rd = 5'd1; in_pending = 1'b0;
        tick();
        idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if (out_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL single_pc got %h want 80000000", out_pc); end
        n_cmp++; if (out_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL single_inst got %h want 00100093", out_inst); end
        n_cmp++; if (out_wdata !== 64'd1) begin n_fail++; $display("FAIL single_wdata got %h want 1", out_wdata); end
        n_cmp++; if (out_rd !== 5'd1) begin n_fail++; $display("FAIL single_rd got %0d want 1", out_rd); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_drain got %0d want 0", count); end
    endtask

    task automatic test_ll_release();
        out_ready = 1'b1;
        retire(64'h100, 64'h55, 5'd5, 1'b1); tick();
        retire(64'h104, 64'd7, 5'd6, 1'b0);  tick();
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL llr_blocked got %b want 0", out_valid); end
        n_cmp++; if (count !== 4'd2) begin n_fail++; $display("FAIL llr_count got %0d want 2", count); end
        n_cmp++; if (out_wdata !== 64'd0) begin n_fail++; $display("FAIL llr_zero_wdata got %h want 0", out_wdata); end
        ll_wen = 1'b1; ll_waddr = 5'd5; ll_wdata = 64'hDEAD;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL llr_no_bypass got %b want 0", out_valid); end
        tick();
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_wdata !== 64'hDEAD) begin
            n_fail++; $display("FAIL llr_first got v=%b pc=%h wd=%h want v=1 pc=100 wd=dead", out_valid, out_pc, out_wdata); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h104 || out_wdata !== 64'd7) begin
            n_fail++; $display("FAIL llr_second got v=%b pc=%h wd=%h want v=1 pc=104 wd=7", out_valid, out_pc, out_wdata); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL llr_drain got %0d want 0", count); end
    endtask

    task automatic test_oldest_and_orphan();
        out_ready = 1'b0;
        retire(64'h200, 64'h0, 5'd3, 1'b1); tick();
        retire(64'h204, 64'h0, 5'd3, 1'b1); tick();
        idle();
        ll_wen = 1'b1; ll_waddr = 5'd3; ll_wdata = 64'h11; tick(); idle();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h200 || out_wdata !== 64'h11) begin
            n_fail++; $display("FAIL oldest got v=%b pc=%h wd=%h want v=1 pc=200 wd=11", out_valid, out_pc, out_wdata); end
        n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_early got %b want 0", err_orphan); end
        ll_wen = 1'b1; ll_waddr = 5'd9; ll_wdata = 64'h99; tick(); idle();
        n_cmp++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_set got %b want 1", err_orphan); end
        n_cmp++; if (count !== 4'd2 || out_wdata !== 64'h11) begin
            n_fail++; $display("FAIL orphan_nochange got cnt=%0d wd=%h want cnt=2 wd=11", count, out_wdata); end
        out_ready = 1'b1; tick();
        n_cmp++; if (out_valid !== 1'b0 || out_pc !== 64'h204) begin
            n_fail++; $display("FAIL younger_pending got v=%b pc=%h want v=0 pc=204", out_valid, out_pc); end
        ll_wen = 1'b1; ll_waddr = 5'd3; ll_wdata = 64'h22; tick(); idle();
        n_cmp++; if (out_valid !== 1'b1 || out_wdata !== 64'h22) begin
            n_fail++; $display("FAIL younger_done got v=%b wd=%h want v=1 wd=22", out_valid, out_wdata); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL oldest_drain got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            retire(64'h1000 + 64'(4 * i), 64'(i + 1), 5'(i + 1), 1'b0); tick();
        end
        n_cmp++; if (count !== 4'd8 || err_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_fill got cnt=%0d ovf=%b want cnt=8 ovf=0", count, err_overflow); end
        retire(64'h1020, 64'd9, 5'd9, 1'b0); tick(); idle();
        n_cmp++; if (count !== 4'd8 || err_overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drop got cnt=%0d ovf=%b want cnt=8 ovf=1", count, err_overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4 * i) || out_wdata !== 64'(i + 1)) begin
                n_fail++; $display("FAIL ovf_order[%0d] got v=%b pc=%h wd=%h want pc=%h wd=%0d", i, out_valid, out_pc,
                                   out_wdata, 64'h1000 + 64'(4 * i), i + 1); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0) begin
            n_fail++; $display("FAIL ovf_ninth got v=%b cnt=%0d want v=0 cnt=0", out_valid, count); end
    endtask

    task automatic test_full_passthrough();
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            retire(64'h3000 + 64'(4 * i), 64'(i), 5'd2, 1'b0); tick();
        end
        out_ready = 1'b1;
        retire(64'h2000, 64'hAB, 5'd4, 1'b0); tick(); idle();
        n_cmp++; if (count !== 4'd8 || err_overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_pass got cnt=%0d ovf=%b want cnt=8 ovf=0", count, err_overflow); end
        n_cmp++; if (out_pc !== 64'h3004) begin n_fail++; $display("FAIL full_pass_head got %h want 3004", out_pc); end
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h2000 || out_wdata !== 64'hAB) begin
            n_fail++; $display("FAIL full_pass_tail got v=%b pc=%h wd=%h want v=1 pc=2000 wd=ab", out_valid, out_pc, out_wdata); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL full_pass_drain got %0d want 0", count); end
    endtask

    task automatic test_timeout_and_reset();
        out_ready = 1'b1;
        do_reset();
        retire(64'h4000, 64'h0, 5'd0, 1'b1); tick(); idle();
        for (int k = 1; k < 16; k++) tick();
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b want 0", err_timeout); end
        tick();
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_at16 got %b want 1", err_timeout); end
        ll_wen = 1'b1; ll_waddr = 5'd0; ll_wdata = 64'h77; tick(); idle();
        n_cmp++; if (out_valid !== 1'b1 || out_wdata !== 64'h77 || err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL rd0_match got v=%b wd=%h tmo=%b want v=1 wd=77 tmo=1", out_valid, out_wdata, err_timeout); end
        out_ready = 1'b0;
        retire(64'h5000, 64'h1, 5'd1, 1'b0);
        ll_wen = 1'b1; ll_waddr = 5'd12;
        reset = 1'b0;
        tick();
        reset = 1'b1; idle();
        n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0 || out_pc !== 64'd0 || out_wdata !== 64'd0) begin
            n_fail++; $display("FAIL mid_reset_out got v=%b cnt=%0d pc=%h wd=%h want all 0", out_valid, count, out_pc, out_wdata); end
        n_cmp++; if ({err_overflow, err_orphan, err_timeout} !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset_errs got %b want 000", {err_overflow, err_orphan, err_timeout}); end
    endtask

    initial begin
        reset = 1'b0;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_single();
        test_ll_release();
        test_oldest_and_orphan();
        test_overflow();
        test_full_passthrough();
        test_timeout_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_aligner.md
Name: commit_trace_aligner

Overview:
- Sits between the core writeback stage and the cosimulation commit checker.
- Captures every retired instruction in program order (pc, inst, wdata, rd).
- Instructions whose result is not ready at writeback (load miss, div, etc.) are held until the matching long-latency writeback arrives, then released in order.
- The checker therefore always sees a retire record that carries final write data.

Parameters:
- DEPTH, 8: number of in-flight retire records buffered; power of two, ≥2.
- XLEN, 64: data and pc width.
- TIMEOUT, 1024: maximum cycles the head may stay pending before error; 0 disables the check.

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-low
- in_valid  input  1  instruction retired this cycle (cannot be stalled)
- in_pc  input  XLEN  retired pc
- in_inst  input  32  retired instruction bits
- in_wdata  input  XLEN  writeback data; don't-care when in_pending=1
- in_rd  input  5  destination register
- in_pending  input  1  result arrives later via ll port
- ll_wen  input  1  long-latency writeback valid
- ll_waddr  input  5  long-latency destination register
- ll_wdata  input  XLEN  long-latency data
- out_valid  output  1  head record complete and presented
- out_ready  input  1  checker accepts record
- out_pc  output  XLEN  head pc
- out_inst  output  32  head instruction
- out_wdata  output  XLEN  head final data
- out_rd  output  5  head destination
- count  output  $clog2(DEPTH+1)  records held
- err_overflow  output  1  sticky: retire dropped while full
- err_orphan  output  1  sticky: ll_wen matched no pending record
- err_timeout  output  1  sticky: head pending ≥ TIMEOUT cycles

Behaviour:
- Reset (reset=0 at a clock edge): all outputs 0, FIFO empty, pointers 0, all entry pending bits 0, timeout counter 0, sticky errors cleared.
- Storage: circular FIFO of DEPTH entries, each holding {pc, inst, wdata, rd, pending}. Wrap pointers carry an extra MSB to distinguish full from empty.
- Enqueue: in_valid writes at the tail at the clock edge; pending=in_pending; wdata=in_wdata, or 0 when pending.
- Head output:
  - out_valid = non-empty AND head.pending=0.
  - out_* are driven combinationally from the head entry and are 0 when empty.
  - Minimum latency from in_valid to out_valid is 1 cycle.
- Dequeue occurs when out_valid && out_ready. A pending head blocks all younger records, so ordering is strict.
- Long-latency match:
  - On ll_wen, select the OLDEST entry present at the start of the cycle with pending=1 and rd==ll_waddr.
  - Write ll_wdata into that entry and clear its pending bit. Exactly one entry is updated.
- No match: no entry changes and err_orphan is set.
- A record enqueued in the same cycle is never an ll_wen match candidate.
- ll_wen on the head entry with out_ready=1: the update lands this edge, out_valid rises the next cycle, and there is no same-cycle bypass.
- Full:
  - in_valid while full with no dequeue this cycle: the record is dropped, err_overflow is set, and FIFO contents are unchanged.
  - Full plus a dequeue in the same cycle: the enqueue is accepted.
- count = entries held; it updates by +1, -1, or 0 for simultaneous enqueue and dequeue.
- Timeout:
  - The counter increments each cycle the FIFO is non-empty and head.pending=1.
  - It clears on any dequeue or when the head is not pending.
  - When count reaches TIMEOUT (TIMEOUT≠0), err_timeout is set; the counter saturates there.
- Sticky errors clear only on reset.
- rd=0 records with in_pending=1 are legal and match ll_waddr=0 normally.

Decomposition:
- Shared package commit_trace_pkg:
  - trace_entry_t struct {pc, inst, wdata, rd, pending} parameterised via XLEN localparam.
  - Pointer-width function clog2-based.
- One sub-module, trace_pending_match:
  - Inputs: DEPTH-bit pending and rd-equality vectors plus head pointer.
  - Output: one-hot oldest match and a hit flag (rotate, priority-encode, rotate back).

Test Plan:
1. Reset, then in_valid with pc=0x80000000, inst=0x00100093, wdata=1, rd=1, pending=0, out_ready=1 -> next cycle out_valid=1, out_pc=0x80000000, out_wdata=1; count returns to 0 after the dequeue.
2. Retire A (load, rd=5, pending=1), then B (rd=6, wdata=7) -> out_valid=0 with count=2. Then ll_wen rd=5, data=0xDEAD -> next cycle out A with wdata=0xDEAD, then B with wdata=7, in order.
3. Two pending records with rd=3 -> the first ll_wen rd=3 completes only the older one. ll_wen rd=9 with nothing pending -> err_orphan=1 and contents unchanged.
4. out_ready=0, 9 retires with DEPTH=8 -> count=8, err_overflow=1. 8 records drain in order, and the 9th is absent.
5. TIMEOUT=16, one pending head, no ll_wen -> err_timeout rises exactly 16 cycles after enqueue. Assert reset=0 mid-operation -> all outputs and errors 0 next cycle.
6. Full FIFO with out_ready=1 and simultaneous in_valid -> accepted, count stays 8, err_overflow stays 0.
